// File: rtl/blink_led_core.sv
// blink_led_core: memory-mapped multi-LED blinker driven by a periodic tick.
// Each LED i toggles every period[i] ticks. A period of 0 parks the LED off.
// Ports:
//   clk, rst   - system clock, asynchronous active-high reset
//   tick       - single-cycle enable pulse from the refresh generator
//   cs, write  - slot select and write strobe (write qualified by cs)
//   read       - read strobe (qualified by cs); no side effects
//   addr       - register index: 0..N_LED-1 period regs, N_LED status
//   wr_data    - write data; only bits [PW-1:0] are stored
//   rd_data    - combinational read data for addr
//   led        - LED drive, bit i = LED i
module blink_led_core #(
  parameter int unsigned N_LED = 4,   // 1..16
  parameter int unsigned PW    = 16   // 1..32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             cs,
  input  logic             write,
  input  logic             read,
  input  logic [4:0]       addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  output logic [N_LED-1:0] led
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam logic [AW-1:0] STATUS_ADDR = AW'(N_LED);

  logic [PW-1:0]    period [N_LED];
  logic [PW-1:0]    cnt    [N_LED];
  logic [N_LED-1:0] wr_hit;
  logic [PW-1:0]    wr_val;

  // Read strobe and upper write-data bits carry no function here.
  logic unused_bits;
  assign unused_bits = ^{read, wr_data};

  assign wr_val = wr_data[PW-1:0];

  // Per-LED write decode.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < int'(N_LED); i++) begin
      wr_hit[i] = cs & write & (addr == AW'(i));
    end
  end

  // Period registers, tick counters and LED toggles.
  // A write to LED i restarts its phase and takes priority over a same-cycle tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_LED); i++) begin
        period[i] <= '0;
        cnt[i]    <= '0;
      end
      led <= '0;
    end else begin
      for (int i = 0; i < int'(N_LED); i++) begin
        if (wr_hit[i]) begin
          period[i] <= wr_val;
          cnt[i]    <= '0;
          led[i]    <= 1'b0;
        end else if (period[i] == '0) begin
          cnt[i] <= '0;
          led[i] <= 1'b0;
        end else if (tick) begin
          if (cnt[i] == period[i] - PW'(1)) begin
            cnt[i] <= '0;
            led[i] <= ~led[i];
          end else begin
            cnt[i] <= cnt[i] + PW'(1);
          end
        end
      end
    end
  end

  // Combinational read mux; unmapped addresses return 0.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(N_LED); i++) begin
      if (addr == AW'(i)) rd_data = DW'(period[i]);
    end
    if (addr == STATUS_ADDR) rd_data = DW'(led);
  end

endmodule

// File: tb/tb_blink_led_core.sv
// tb_blink_led_core: directed scoreboard bench for blink_led_core.
// Stimulus pushes expected {rd_data, led} for each read; a negedge monitor
// pops and compares whenever a read (cs & read) is presented to the DUT.
module tb_blink_led_core;

  localparam int unsigned N_LED = 4;
  localparam int unsigned PW    = 16;
  localparam logic [4:0]  ST    = 5'(N_LED);

  logic             clk;
  logic             rst;
  logic             tick;
  logic             cs;
  logic             write;
  logic             read;
  logic [4:0]       addr;
  logic [31:0]      wr_data;
  logic [31:0]      rd_data;
  logic [N_LED-1:0] led;

  int checks = 0;
  int errors = 0;

  logic [31:0]      exp_rd_q  [$];
  logic [N_LED-1:0] exp_led_q [$];
  string            name_q    [$];

  blink_led_core #(.N_LED(N_LED), .PW(PW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .cs(cs), .write(write), .read(read),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare each presented read against the scoreboard head.
  always @(negedge clk) begin
    if (cs && read) begin
      if (exp_rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read addr=%0d rd_data=0x%08h (no expectation queued)", addr, rd_data);
      end else begin
        automatic logic [31:0]      e_rd  = exp_rd_q.pop_front();
        automatic logic [N_LED-1:0] e_led = exp_led_q.pop_front();
        automatic string            nm    = name_q.pop_front();
        checks++;
        if (rd_data !== e_rd) begin
          errors++;
          $display("FAIL %s rd_data: got 0x%08h want 0x%08h", nm, rd_data, e_rd);
        end
        checks++;
        if (led !== e_led) begin
          errors++;
          $display("FAIL %s led: got %b want %b", nm, led, e_led);
        end
      end
    end
  end

  // One bus cycle starting just after a rising edge.
  task automatic drive(input logic t, input logic w, input logic r,
                       input logic [4:0] a, input logic [31:0] d);
    tick = t; cs = w | r; write = w; read = r; addr = a; wr_data = d;
    @(posedge clk); #1;
    tick = 1'b0; cs = 1'b0; write = 1'b0; read = 1'b0; addr = '0; wr_data = '0;
  endtask

  task automatic expect_rd(input logic [31:0] e_rd, input logic [N_LED-1:0] e_led, input string nm);
    exp_rd_q.push_back(e_rd);
    exp_led_q.push_back(e_led);
    name_q.push_back(nm);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e_rd,
                    input logic [N_LED-1:0] e_led, input string nm);
    expect_rd(e_rd, e_led, nm);
    drive(1'b0, 1'b0, 1'b1, a, '0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic tk();
    drive(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Hand-computed LED0 after tick k (period 3): toggles at 3, 6, 9, 12.
  logic [N_LED-1:0] blink_tab [12] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                                       4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
  // Status after each of 4 ticks with periods {3 (mid-phase), 1, 2, 0}.
  logic [N_LED-1:0] indep_tab [4] = '{4'b0010, 4'b0100, 4'b0111, 4'b0001};

  initial begin
    rst = 1'b1; tick = 1'b0; cs = 1'b0; write = 1'b0; read = 1'b0;
    addr = '0; wr_data = '0;
    @(posedge clk); #1;

    // Reset held 3 cycles with tick toggling; reads see zeros.
    for (int i = 0; i < 3; i++) begin
      expect_rd(32'h0, 4'b0000, "reset_read");
      drive(1'(i % 2 == 0), 1'b0, 1'b1, 5'(i), '0);
    end
    rst = 1'b0;
    rd(5'd3, 32'h0, 4'b0000, "post_reset_addr3");
    rd(ST,   32'h0, 4'b0000, "post_reset_status");
    for (int i = 0; i < 4; i++) tk();
    rd(ST,   32'h0, 4'b0000, "idle_periods_zero");

    // Basic blink, period 3, ticks 5 cycles apart.
    wr(5'd0, 32'd3);
    for (int k = 0; k < 12; k++) begin
      tk();
      rd(ST, 32'(blink_tab[k]), blink_tab[k], $sformatf("blink_tick%0d", k + 1));
      idle(3);
    end

    // Period 1 and period 2 running alongside LED0.
    wr(5'd1, 32'd1);
    wr(5'd2, 32'd2);
    for (int k = 0; k < 4; k++) begin
      tk();
      rd(ST, 32'(indep_tab[k]), indep_tab[k], $sformatf("indep_tick%0d", k + 1));
    end
    rd(5'd1, 32'd1, 4'b0001, "readback_p1");
    rd(5'd2, 32'd2, 4'b0001, "readback_p2");

    // Write/tick collision on LED0 while LED1 keeps counting.
    wr(5'd2, 32'd0);
    wr(5'd1, 32'd1);
    wr(5'd0, 32'd2);
    tk();
    rd(ST, 32'h2, 4'b0010, "coll_pre");
    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'd2);
    rd(ST, 32'h0, 4'b0000, "coll_write_wins");
    tk();
    rd(ST, 32'h2, 4'b0010, "coll_after1");
    tk();
    rd(ST, 32'h1, 4'b0001, "coll_after2_toggle");

    // Width and address rules.
    wr(5'd1, 32'd0);
    wr(5'd0, 32'hFFFF_0005);
    rd(5'd0,  32'h0000_0005, 4'b0000, "width_trunc");
    wr(5'd20, 32'h0000_1234);
    rd(5'd20, 32'h0, 4'b0000, "addr20_read");
    rd(5'd0,  32'h0000_0005, 4'b0000, "addr20_no_effect");
    rd(5'd31, 32'h0, 4'b0000, "addr31_read");
    wr(5'd0, 32'd1);
    tk();
    rd(ST, 32'h1, 4'b0001, "p1_toggle");
    wr(5'd0, 32'd0);
    rd(ST, 32'h0, 4'b0000, "period0_clears");
    tk(); tk();
    rd(ST, 32'h0, 4'b0000, "period0_held");

    // Async reset between edges mid-count.
    wr(5'd1, 32'd7);
    wr(5'd0, 32'd3);
    for (int k = 0; k < 5; k++) tk();
    rd(ST, 32'h1, 4'b0001, "pre_async");
    expect_rd(32'h0, 4'b0000, "async_reset_clear");
    cs = 1'b1; read = 1'b1; addr = ST;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    cs = 1'b0; read = 1'b0; addr = '0;
    rd(5'd0, 32'h0, 4'b0000, "async_p0");
    rd(5'd1, 32'h0, 4'b0000, "async_p1");
    for (int k = 0; k < 3; k++) tk();
    rd(ST, 32'h0, 4'b0000, "async_no_resume");

    // Every queued expectation must have been consumed.
    @(negedge clk);
    checks++;
    if (exp_rd_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_rd_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/blink_led_core.md
# blink_led_core

Memory-mapped LED blinker that consumes the periodic millisecond tick from the refresh-rate generator and toggles each of N_LED outputs at a software-programmed period. It sits in an MMIO slot of the softcore SoC: the CPU writes per-LED half-periods over the slot bus, and the core drives the board LEDs. It is the receiving end of the refresh tick: the generator produces the tick, and this block counts it.

## Interface
- N_LED, default 4: number of independently blinking LEDs (1..16).
- PW, default 16: width of each period register and counter, in ticks.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  single-cycle enable pulse from the refresh generator, nominally 1 ms; assumed never high on consecutive cycles, tolerated if it is.
- cs  in  1  slot select.
- write  in  1  write strobe; qualified by cs.
- read  in  1  read strobe; qualified by cs; informational only, no side effects.
- addr  in  5  register index.
- wr_data  in  32  write data; bits [PW-1:0] used, upper bits ignored.
- rd_data  out  32  read data, combinational from addr.
- led  out  N_LED  LED drive, bit i = LED i.

## Operation
- Registers: addr i (i < N_LED) = period[i] (RW). addr N_LED = status (RO) returns led zero-extended. Other addresses: writes ignored, reads return 0.
- rd_data = {0, period[addr]} or status, zero-extended, valid the same cycle as addr.
- Per LED i: counter cnt[i] (PW bits), output led[i].
- period[i] = 0: led[i] held 0, cnt[i] held 0, tick ignored.
- period[i] = P > 0, on each tick: if cnt[i] == P-1, then cnt[i] <= 0 and led[i] <= ~led[i]; else cnt[i] <= cnt[i]+1. Result: led[i] toggles every P ticks, so the full blink period is 2P ticks.
- Write to addr i (cs & write): period[i] <= wr_data[PW-1:0], cnt[i] <= 0, led[i] <= 0 at the same edge. This restarts the phase even if the written value equals the old value.
- A write to LED i on a tick cycle: the write wins for LED i; that tick is not counted for i. Other LEDs count the tick normally.
- Counter comparison is equality against P-1 at PW-bit width. No wrap past P-1 can occur because a write resets cnt.
- Max period 2^PW-1 ticks. P = 1 toggles on every tick.

## Timing
- Reset (async assert, sync to clk on release): period[*] = 0, cnt[*] = 0, led = 0. rd_data reflects the reset registers immediately (0 for all addresses).
- Write latency: register visible on rd_data the cycle after the write edge.
- Toggle latency: led[i] changes at the clk edge on which the qualifying tick is sampled high; visible in the next cycle.
- Reset asserted mid-count clears all state without waiting for clk. After deassertion, counting resumes only after software reprograms the periods.
- No handshake or wait states: every bus access completes in one cycle.

## Test plan
- Reset: assert rst for 3 cycles with tick toggling -> led = 0; rd_data = 0 for addr 0..N_LED; no toggles afterwards while periods = 0.
- Basic blink: write period[0] = 3, issue 12 ticks spaced 5 cycles apart -> led[0] toggles at ticks 3, 6, 9 and 12 (0→1→0→1→0); other LEDs stay 0; status reads track led.
- Period 1 and independence: period[1] = 1, period[2] = 2, 4 ticks -> led[1] toggles 4 times, led[2] toggles 2 times; readback of addr 1 = 1 and addr 2 = 2.
- Write/tick collision: period[0] = 2, after 1 tick (cnt = 1) write period[0] = 2 in the same cycle as the next tick -> no toggle, cnt = 0, led[0] = 0; the next toggle comes 2 ticks later.
- Width/address rules: write 0xFFFF_0005 to addr 0 -> readback 0x0000_0005. Write to addr 20 -> no state change, read of addr 20 = 0. Write period 0 while led = 1 -> led = 0 immediately and held.
- Async reset mid-operation: led[0] = 1 with cnt = 2, pulse rst between clk edges -> led and counters clear before the next edge; periods read 0.
